spi_master: RTL and testbench

Byte-oriented SPI master that serialises one 8-bit word per transaction onto MOSI while simultaneously capturing 8 bits from MISO, generating SCL and CS_n from the system clock. It is the initiating end of the existing `spi_interface` master modport (drives SCL, CS_n, MOSI; receives MISO) and presents a valid/ready byte interface to the host logic. All four SPI modes are supported, selected per transaction.

---
 rtl/spi_master.sv | 187 ++++++++++++++++++
 tb/tb_spi_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: byte-oriented SPI master with a valid/ready host side.
// Sends one byte on MOSI while capturing one byte from MISO, in any of the four
// SPI modes chosen per transaction. CLK_DIV sets the SCL half-period in clk cycles.
// Optional build macro SPI_MASTER_LSB_FIRST_EN: shift bit 0 first instead of bit 7.
`timescale 1ns/1ps

module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic [1:0] mode,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       SCL,
    output logic       CS_n,
    output logic       MOSI,
    input  logic       MISO
);

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_EDGE = 5'd16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] div_cnt, div_cnt_nxt;
    logic [4:0] edge_cnt, edge_cnt_nxt;
    logic [7:0] tx_shift, tx_shift_nxt;
    logic [7:0] rx_shift, rx_shift_nxt;
    logic       cpol, cpol_nxt;
    logic       cpha, cpha_nxt;
    logic       scl_nxt;
    logic       cs_n_nxt;
    logic       mosi_nxt;
    logic [7:0] rx_data_nxt;
    logic       rx_valid_nxt;

    logic       half_done;
    logic [4:0] edge_num;
    logic       sample_now;

    // Bit that leaves the shift register first.
    function automatic logic first_bit(input logic [7:0] b);
        return LSB_FIRST ? b[0] : b[7];
    endfunction

    // Shift register after the outgoing bit has been handed to MOSI.
    function automatic logic [7:0] shift_out(input logic [7:0] b);
        return LSB_FIRST ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
    endfunction

    // Receive register after one more MISO bit has been captured.
    function automatic logic [7:0] shift_in(input logic [7:0] b, input logic bit_in);
        return LSB_FIRST ? {bit_in, b[7:1]} : {b[6:0], bit_in};
    endfunction

    assign half_done  = (div_cnt == DIV_LAST);
    assign edge_num   = edge_cnt + 5'd1;
    // Odd edges are leading; CPHA=0 samples on leading, CPHA=1 on trailing.
    assign sample_now = edge_num[0] ^ cpha;
    assign tx_ready   = (state == IDLE);

    // Next-state and next-output decode; every SCL edge is produced together with its MOSI/MISO action.
    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt + 8'd1;
        edge_cnt_nxt = edge_cnt;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        cpol_nxt     = cpol;
        cpha_nxt     = cpha;
        scl_nxt      = SCL;
        cs_n_nxt     = CS_n;
        mosi_nxt     = MOSI;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                div_cnt_nxt = '0;
                scl_nxt     = cpol;
                cs_n_nxt    = 1'b1;
                if (tx_valid) begin
                    state_nxt    = SETUP;
                    cpol_nxt     = mode[1];
                    cpha_nxt     = mode[0];
                    scl_nxt      = mode[1];
                    cs_n_nxt     = 1'b0;
                    edge_cnt_nxt = '0;
                    rx_shift_nxt = '0;
                    if (!mode[0]) begin
                        mosi_nxt     = first_bit(tx_data);
                        tx_shift_nxt = shift_out(tx_data);
                    end else begin
                        tx_shift_nxt = tx_data;
                    end
                end
            end

            SETUP, XFER: begin
                if (half_done) begin
                    div_cnt_nxt  = '0;
                    edge_cnt_nxt = edge_num;
                    scl_nxt      = ~SCL;
                    state_nxt    = (edge_num == LAST_EDGE) ? HOLD : XFER;
                    if (sample_now) begin
                        rx_shift_nxt = shift_in(rx_shift, MISO);
                    end else if (cpha || (edge_num != LAST_EDGE)) begin
                        mosi_nxt     = first_bit(tx_shift);
                        tx_shift_nxt = shift_out(tx_shift);
                    end
                end
            end

            HOLD: begin
                if (half_done) begin
                    state_nxt    = GAP;
                    div_cnt_nxt  = '0;
                    cs_n_nxt     = 1'b1;
                    mosi_nxt     = 1'b0;
                    rx_data_nxt  = rx_shift;
                    rx_valid_nxt = 1'b1;
                end
            end

            GAP: begin
                if (half_done) begin
                    state_nxt   = IDLE;
                    div_cnt_nxt = '0;
                end
            end

            default: begin
                state_nxt   = IDLE;
                div_cnt_nxt = '0;
            end
        endcase
    end

    // State, datapath and registered SPI outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            SCL      <= 1'b0;
            CS_n     <= 1'b1;
            MOSI     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_cnt_nxt;
            edge_cnt <= edge_cnt_nxt;
            tx_shift <= tx_shift_nxt;
            rx_shift <= rx_shift_nxt;
            cpol     <= cpol_nxt;
            cpha     <= cpha_nxt;
            SCL      <= scl_nxt;
            CS_n     <= cs_n_nxt;
            MOSI     <= mosi_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master (CLK_DIV = 4).
// Log index n holds the value an output presents to rising edge n, counting the
// accept edge as edge 0, so it lines up with the cycle numbers of the timing plan.
`timescale 1ns/1ps

module tb_spi_master;

    localparam int CLK_DIV = 4;
    localparam int LOG_MAX = 160;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [1:0] mode;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       SCL;
    logic       CS_n;
    logic       MOSI;
    logic       MISO;

    int checkCount = 0;
    int errorCount = 0;

    logic csLog   [0:LOG_MAX-1];
    logic sclLog  [0:LOG_MAX-1];
    logic mosiLog [0:LOG_MAX-1];
    logic rxvLog  [0:LOG_MAX-1];
    logic rdyLog  [0:LOG_MAX-1];
    int   logLen = 0;
    logic [7:0] rxQ [$];

    logic       loopback = 1'b1;
    logic [1:0] slaveMode = 2'd0;
    logic [7:0] slaveTxByte = 8'h00;
    logic [7:0] slaveShiftOut = 8'h00;
    logic [7:0] slaveRx = 8'h00;
    int         slaveBits = 0;
    logic       slaveMiso = 1'b0;
    logic       prevScl = 1'b0;
    logic       prevCs = 1'b1;

    assign MISO = loopback ? MOSI : slaveMiso;

    spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .mode     (mode),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .SCL      (SCL),
        .CS_n     (CS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

`ifdef SPI_MASTER_LSB_FIRST_EN
    function automatic logic slaveFirstBit(input logic [7:0] b);
        return b[0];
    endfunction
    function automatic logic [7:0] slaveShift(input logic [7:0] b);
        return {1'b0, b[7:1]};
    endfunction
    function automatic logic [7:0] slaveCapture(input logic [7:0] b, input logic v);
        return {v, b[7:1]};
    endfunction
`else
    function automatic logic slaveFirstBit(input logic [7:0] b);
        return b[7];
    endfunction
    function automatic logic [7:0] slaveShift(input logic [7:0] b);
        return {b[6:0], 1'b0};
    endfunction
    function automatic logic [7:0] slaveCapture(input logic [7:0] b, input logic v);
        return {b[6:0], v};
    endfunction
`endif

    // Responder model: watches SCL/CS_n half a clock after they move and acts on leading/trailing edges.
    always @(negedge clk) begin
        if (CS_n == 1'b0 && prevCs == 1'b1) begin
            slaveRx   <= 8'h00;
            slaveBits <= 0;
            if (!slaveMode[0]) begin
                slaveMiso     <= slaveFirstBit(slaveTxByte);
                slaveShiftOut <= slaveShift(slaveTxByte);
            end else begin
                slaveShiftOut <= slaveTxByte;
            end
        end else if (CS_n == 1'b0 && SCL != prevScl) begin
            if ((SCL != slaveMode[1]) != slaveMode[0]) begin
                slaveRx   <= slaveCapture(slaveRx, MOSI);
                slaveBits <= slaveBits + 1;
            end else begin
                slaveMiso     <= slaveFirstBit(slaveShiftOut);
                slaveShiftOut <= slaveShift(slaveShiftOut);
            end
        end
        prevScl <= SCL;
        prevCs  <= CS_n;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Offer one byte, then log every output for nCycles; data/mode switch to d2/m2 right after accept.
    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] d,
                                 input logic [1:0] m2, input logic [7:0] d2,
                                 input int dropAt, input int nCycles);
        int waitCnt;
        @(negedge clk);
        tx_valid  = 1'b1;
        tx_data   = d;
        mode      = m;
        slaveMode = m;
        waitCnt   = 0;
        while (!tx_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("accept_ready", tx_ready, 1'b1);
        rxQ.delete();
        csLog[0]   = CS_n;
        sclLog[0]  = SCL;
        mosiLog[0] = MOSI;
        rxvLog[0]  = rx_valid;
        rdyLog[0]  = tx_ready;
        for (int n = 1; n < nCycles; n++) begin
            @(negedge clk);
            if (n == 1) begin
                tx_data = d2;
                mode    = m2;
            end
            if (n == dropAt) tx_valid = 1'b0;
            csLog[n]   = CS_n;
            sclLog[n]  = SCL;
            mosiLog[n] = MOSI;
            rxvLog[n]  = rx_valid;
            rdyLog[n]  = tx_ready;
            if (rx_valid) rxQ.push_back(rx_data);
        end
        logLen = nCycles;
    endtask

    // Timing of one transaction accepted at log index start.
    task automatic analyzeTransfer(input string tag, input int start, input logic expCpol);
        int csFall = -1;
        int csRise = -1;
        int rxvAt = -1;
        int rdyAt = -1;
        int rxvCount = 0;
        int edges = 0;
        int firstEdge = -1;
        int lastEdge = -1;
        int overlap = 0;
        int doubled = 0;
        for (int n = start + 1; n <= start + 73 && n < logLen; n++) begin
            if (csFall < 0 && csLog[n] == 1'b0) csFall = n;
            else if (csFall >= 0 && csRise < 0 && csLog[n] == 1'b1) csRise = n;
            if (rxvLog[n]) begin
                rxvCount++;
                if (rxvAt < 0) rxvAt = n;
                if (csLog[n] == 1'b0) overlap++;
                if (rxvLog[n-1]) doubled++;
            end
            if (rdyAt < 0 && rdyLog[n]) rdyAt = n;
            if (n > start + 1 && sclLog[n] != sclLog[n-1]) begin
                edges++;
                if (firstEdge < 0) firstEdge = n;
                lastEdge = n;
            end
        end
        checkOutput({tag, ".cs_fall"},   csFall - start, 1);
        checkOutput({tag, ".cs_rise"},   csRise - start, 69);
        checkOutput({tag, ".rxv_cycle"}, rxvAt - start, 69);
        checkOutput({tag, ".rxv_count"}, rxvCount, 1);
        checkOutput({tag, ".ready"},     rdyAt - start, 73);
        checkOutput({tag, ".edges"},     edges, 16);
        checkOutput({tag, ".edge1"},     firstEdge - start, 5);
        checkOutput({tag, ".edge16"},    lastEdge - start, 65);
        checkOutput({tag, ".scl_setup"}, sclLog[start+1], expCpol);
        checkOutput({tag, ".scl_idle"},  sclLog[start+73], expCpol);
        checkOutput({tag, ".rxv_cs_low"}, overlap, 0);
        checkOutput({tag, ".rxv_double"}, doubled, 0);
    endtask

    // MOSI may only move on SCL edges of the given parity (1 = leading, 0 = trailing) while CS_n is low.
    task automatic checkMosiEdges(input string tag, input int expParity, input int expCount);
        int edgeIdx = 0;
        int onEdge = 0;
        int offEdge = 0;
        for (int n = 2; n <= 68; n++) begin
            if (sclLog[n] != sclLog[n-1]) edgeIdx++;
            if (mosiLog[n] != mosiLog[n-1]) begin
                if (sclLog[n] != sclLog[n-1] && (edgeIdx % 2) == expParity) onEdge++;
                else offEdge++;
            end
        end
        checkOutput({tag, ".mosi_off_edge"}, offEdge, 0);
        checkOutput({tag, ".mosi_on_edge"},  onEdge, expCount);
    endtask

    // Hard stop if the sequence below ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int toggles;
        int cyc;
        int pulses;
        int csLow;
        int hiCount;
        int firstHi;
        logic prevSclLocal;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        mode     = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.tx_ready", tx_ready, 1'b1);
        checkOutput("reset.cs_n",     CS_n, 1'b1);
        checkOutput("reset.scl",      SCL, 1'b0);
        checkOutput("reset.mosi",     MOSI, 1'b0);
        checkOutput("reset.rx_valid", rx_valid, 1'b0);
        checkOutput("reset.rx_data",  rx_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] mode 0 loopback 0xA5");
        loopback = 1'b1;
        applyStimulus(2'd0, 8'hA5, 2'd3, 8'h5A, 1, 80);
        analyzeTransfer("m0", 0, 1'b0);
        checkOutput("m0.scl_pre", sclLog[0], 1'b0);
        checkOutput("m0.rx_count", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("m0.rx_data", rxQ[0], 8'hA5);

        $display("[TB] mode 3 responder 0x3C");
        loopback    = 1'b0;
        slaveTxByte = 8'h3C;
        applyStimulus(2'd3, 8'hC3, 2'd0, 8'h3C, 1, 80);
        analyzeTransfer("m3", 0, 1'b1);
        checkOutput("m3.rx_count", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("m3.rx_data", rxQ[0], 8'h3C);
        checkOutput("m3.slave_rx",   slaveRx, 8'hC3);
        checkOutput("m3.slave_bits", slaveBits, 8);
        checkMosiEdges("m3", 1, 3);

        $display("[TB] mode 1 responder 0x7E");
        slaveTxByte = 8'h7E;
        applyStimulus(2'd1, 8'h81, 2'd2, 8'h7E, 1, 80);
        analyzeTransfer("m1", 0, 1'b0);
        checkOutput("m1.rx_count", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("m1.rx_data", rxQ[0], 8'h7E);
        checkOutput("m1.slave_rx", slaveRx, 8'h81);
        checkMosiEdges("m1", 1, 3);

        // CPHA=0: after the setup bit MOSI moves on trailing edges, which for CPOL=1 are rising.
        $display("[TB] mode 2 responder 0x7E");
        applyStimulus(2'd2, 8'h81, 2'd1, 8'h7E, 1, 80);
        analyzeTransfer("m2", 0, 1'b1);
        checkOutput("m2.rx_count", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("m2.rx_data", rxQ[0], 8'h7E);
        checkOutput("m2.slave_rx", slaveRx, 8'h81);
        checkMosiEdges("m2", 0, 2);

        $display("[TB] back-to-back 0x11 then 0x22");
        loopback = 1'b1;
        applyStimulus(2'd0, 8'h11, 2'd0, 8'h22, 74, 150);
        analyzeTransfer("b2b_first", 0, 1'b0);
        analyzeTransfer("b2b_second", 73, 1'b0);
        checkOutput("b2b.rx_count", rxQ.size(), 2);
        if (rxQ.size() > 1) begin
            checkOutput("b2b.rx_first",  rxQ[0], 8'h11);
            checkOutput("b2b.rx_second", rxQ[1], 8'h22);
        end
        csLow = 0;
        for (int n = 69; n <= 73; n++) if (csLog[n] == 1'b0) csLow++;
        checkOutput("b2b.cs_gap_low", csLow, 0);

        $display("[TB] reset at SCL edge 7");
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        mode     = 2'd0;
        @(posedge clk);
        @(negedge clk);
        tx_valid     = 1'b0;
        toggles      = 0;
        cyc          = 0;
        prevSclLocal = SCL;
        while (toggles < 7 && cyc < 200) begin
            @(negedge clk);
            if (SCL != prevSclLocal) toggles++;
            prevSclLocal = SCL;
            cyc++;
        end
        checkOutput("rst.edge7_seen", toggles, 7);
        checkOutput("rst.scl_before", SCL, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.cs_n",     CS_n, 1'b1);
        checkOutput("rst.scl",      SCL, 1'b0);
        checkOutput("rst.mosi",     MOSI, 1'b0);
        checkOutput("rst.tx_ready", tx_ready, 1'b1);
        checkOutput("rst.rx_valid", rx_valid, 1'b0);
        checkOutput("rst.rx_data",  rx_data, 8'h00);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        csLow  = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (rx_valid) pulses++;
            if (!CS_n) csLow++;
        end
        checkOutput("rst.no_rx_valid", pulses, 0);
        checkOutput("rst.cs_idle", csLow, 0);
        applyStimulus(2'd0, 8'h5A, 2'd1, 8'hA5, 1, 80);
        analyzeTransfer("rst_after", 0, 1'b0);
        checkOutput("rst_after.rx_count", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("rst_after.rx_data", rxQ[0], 8'h5A);

        $display("[TB] bit order with 0x01");
        applyStimulus(2'd0, 8'h01, 2'd3, 8'hFE, 1, 80);
        hiCount = 0;
        firstHi = -1;
        for (int n = 1; n < 80; n++) begin
            if (mosiLog[n]) begin
                hiCount++;
                if (firstHi < 0) firstHi = n;
            end
        end
`ifdef SPI_MASTER_LSB_FIRST_EN
        checkOutput("order.mosi_high_cycles", hiCount, 8);
        checkOutput("order.mosi_first_high",  firstHi, 1);
`else
        checkOutput("order.mosi_high_cycles", hiCount, 12);
        checkOutput("order.mosi_first_high",  firstHi, 57);
`endif
        checkOutput("order.rx_count", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("order.rx_data", rxQ[0], 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
